// File: rtl/mem_responder.sv
// Single-ported 16-bit word memory answering split instruction/data request ports
// with a fixed access latency and one registered response pulse per accepted request.
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3,
  parameter int ARB_RR    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instruction_request,
  input  logic [15:0] instruction_address,
  output logic [15:0] instr,
  output logic        instruction_response,
  input  logic        data_request,
  input  logic        write_enable,
  input  logic [15:0] mem_address,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] write_data,
  output logic [15:0] mem_rdata,
  output logic        data_response
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic       PORT_D   = 1'b0;
  localparam logic       PORT_I   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rr_q, rr_d;
  logic                  port_q, port_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  we_q, we_d;
  logic [1:0]            be_q, be_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           instr_q, instr_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  iresp_q, iresp_d;
  logic                  dresp_q, dresp_d;
  logic                  pick_i;
  logic                  enter_resp;
  logic                  mem_we;
  logic [15:0]           cur_word;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_q [2**ADDR_BITS];
  logic                  unused_addr_bits;

  // Byte-address bit 0 and bits above the word index are don't-cares.
  assign unused_addr_bits = ^{instruction_address, mem_address};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    port_d  = port_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    pick_i  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instruction_request || data_request) begin
          pick_i = instruction_request &&
                   (!data_request || (ARB_RR != 0 && rr_q == PORT_I));
          if (instruction_request && data_request && ARB_RR != 0) rr_d = ~rr_q;
          port_d  = pick_i ? PORT_I : PORT_D;
          addr_d  = pick_i ? instruction_address[ADDR_BITS:1] : mem_address[ADDR_BITS:1];
          we_d    = !pick_i && write_enable;
          be_d    = mem_byte_enable;
          wdata_d = write_data;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The access completes on the edge that enters RESP, whichever state it comes from.
    enter_resp = (state_d == RESP) && (state_q != RESP);
    cur_word   = mem_q[addr_d];
    mem_wdata  = {be_d[1] ? wdata_d[15:8] : cur_word[15:8],
                  be_d[0] ? wdata_d[7:0]  : cur_word[7:0]};
    mem_we     = 1'b0;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    iresp_d    = enter_resp && (port_d == PORT_I);
    dresp_d    = enter_resp && (port_d == PORT_D);
    if (enter_resp) begin
      if (we_d)                 mem_we  = 1'b1;
      else if (port_d == PORT_I) instr_d = cur_word;
      else                      rdata_d = cur_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rr_q    <= PORT_D;
      port_q  <= PORT_D;
      instr_q <= 16'h0000;
      rdata_q <= 16'h0000;
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      iresp_q <= iresp_d;
      dresp_q <= dresp_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  // A store is only committed on the RESP entry edge, so a reset before then drops it.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem_q[addr_d] <= mem_wdata;
  end

  assign instr                = instr_q;
  assign mem_rdata            = rdata_q;
  assign instruction_response = iresp_q;
  assign data_response        = dresp_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, latency, byte lanes, arbitration,
// reset abort and address aliasing, with hand-computed expectations.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instruction_request = 1'b0;
  logic [15:0] instruction_address = 16'h0;
  logic [15:0] instr;
  logic        instruction_response;
  logic        data_request = 1'b0;
  logic        write_enable = 1'b0;
  logic [15:0] mem_address = 16'h0;
  logic [1:0]  mem_byte_enable = 2'b11;
  logic [15:0] write_data = 16'h0;
  logic [15:0] mem_rdata;
  logic        data_response;

  logic        ireq_b = 1'b0;
  logic [15:0] iaddr_b = 16'h0;
  logic [15:0] instr_b;
  logic        iresp_b;
  logic        dreq_b = 1'b0;
  logic        we_b = 1'b0;
  logic [15:0] daddr_b = 16'h0;
  logic [1:0]  be_b = 2'b11;
  logic [15:0] wd_b = 16'h0;
  logic [15:0] rdata_b;
  logic        dresp_b;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.ADDR_BITS(10), .LATENCY(3), .ARB_RR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instruction_request(instruction_request), .instruction_address(instruction_address),
    .instr(instr), .instruction_response(instruction_response),
    .data_request(data_request), .write_enable(write_enable), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .write_data(write_data),
    .mem_rdata(mem_rdata), .data_response(data_response)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(3), .ARB_RR(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .instruction_request(ireq_b), .instruction_address(iaddr_b),
    .instr(instr_b), .instruction_response(iresp_b),
    .data_request(dreq_b), .write_enable(we_b), .mem_address(daddr_b),
    .mem_byte_enable(be_b), .write_data(wd_b),
    .mem_rdata(rdata_b), .data_response(dresp_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access on the round-robin instance; inputs are scrambled right after accept.
  task automatic access(input string tag, input bit is_i, input bit we, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd, output logic [15:0] rd);
    int lat;
    lat = -1;
    if (is_i) begin
      instruction_request = 1'b1;
      instruction_address = a;
    end else begin
      data_request    = 1'b1;
      write_enable    = we;
      mem_address     = a;
      mem_byte_enable = be;
      write_data      = wd;
    end
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        instruction_address = ~a;
        mem_address         = ~a;
        write_data          = ~wd;
        mem_byte_enable     = ~be;
        write_enable        = ~we;
      end
      if (is_i ? instruction_response : data_response) lat = c;
    end
    chk({tag, "_lat"}, lat, 3);
    rd = is_i ? instr : mem_rdata;
    instruction_request = 1'b0;
    data_request        = 1'b0;
    write_enable        = 1'b0;
    @(posedge clk); #1;
  endtask

  // Both ports requested together; each drops its request once answered.
  task automatic tie(input string tag, input bit b, output int d_at, output int i_at,
                     output logic [15:0] d_val, output logic [15:0] i_val);
    d_at = -1; i_at = -1; d_val = 16'h0; i_val = 16'h0;
    if (b) begin ireq_b = 1'b1; dreq_b = 1'b1; we_b = 1'b0; end
    else begin instruction_request = 1'b1; data_request = 1'b1; write_enable = 1'b0; end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (b) begin
        chk({tag, "_excl"}, {31'd0, dresp_b & iresp_b}, 32'd0);
        if (dresp_b && d_at < 0) begin d_at = c; d_val = rdata_b; dreq_b = 1'b0; end
        if (iresp_b && i_at < 0) begin i_at = c; i_val = instr_b; ireq_b = 1'b0; end
      end else begin
        chk({tag, "_excl"}, {31'd0, data_response & instruction_response}, 32'd0);
        if (data_response && d_at < 0) begin
          d_at = c; d_val = mem_rdata; data_request = 1'b0;
        end
        if (instruction_response && i_at < 0) begin
          i_at = c; i_val = instr; instruction_request = 1'b0;
        end
      end
    end
    ireq_b = 1'b0; dreq_b = 1'b0; instruction_request = 1'b0; data_request = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] dv, iv;
    int da, ia;
    logic seen;

    // Reset held with both requests high
    rst_n = 1'b0;
    instruction_request = 1'b1;
    data_request = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("rst_iresp", {31'd0, instruction_response}, 32'd0);
      chk("rst_dresp", {31'd0, data_response}, 32'd0);
    end
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_rdata", {16'd0, mem_rdata}, 32'd0);
    rst_n = 1'b1;
    instruction_address = 16'h0000;
    mem_address = 16'h0000;
    tie("post_rst", 1'b0, da, ia, dv, iv);
    chk("post_rst_d_at", da, 3);
    chk("post_rst_i_at", ia, 7);

    // Store then fetch; a known load first pins mem_rdata
    access("st100", 1'b0, 1'b1, 16'h0100, 2'b11, 16'h0F0F, rd);
    access("ld100", 1'b0, 1'b0, 16'h0100, 2'b00, 16'h0000, rd);
    chk("ld100", {16'd0, rd}, 32'h0F0F);
    access("st40", 1'b0, 1'b1, 16'h0040, 2'b11, 16'h1234, rd);
    chk("st40_rdata_kept", {16'd0, mem_rdata}, 32'h0F0F);
    access("fe40", 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, rd);
    chk("fe40", {16'd0, rd}, 32'h1234);
    chk("fe40_rdata_kept", {16'd0, mem_rdata}, 32'h0F0F);

    // Byte lanes
    access("st10", 1'b0, 1'b1, 16'h0010, 2'b11, 16'hAAAA, rd);
    access("st10_be01", 1'b0, 1'b1, 16'h0010, 2'b01, 16'h1155, rd);
    access("ld10a", 1'b0, 1'b0, 16'h0010, 2'b00, 16'h0000, rd);
    chk("ld10a", {16'd0, rd}, 32'hAA55);
    access("st10_be10", 1'b0, 1'b1, 16'h0010, 2'b10, 16'h33FF, rd);
    access("ld10b", 1'b0, 1'b0, 16'h0010, 2'b01, 16'h0000, rd);
    chk("ld10b", {16'd0, rd}, 32'h3355);
    access("st10_be00", 1'b0, 1'b1, 16'h0010, 2'b00, 16'h9999, rd);
    access("ld10c", 1'b0, 1'b0, 16'h0010, 2'b00, 16'h0000, rd);
    chk("ld10c", {16'd0, rd}, 32'h3355);

    // Address aliasing above ADDR_BITS
    access("st802", 1'b0, 1'b1, 16'h0802, 2'b11, 16'h5A5A, rd);
    access("ld002", 1'b0, 1'b0, 16'h0002, 2'b00, 16'h0000, rd);
    chk("ld002", {16'd0, rd}, 32'h5A5A);
    access("ld003", 1'b0, 1'b0, 16'h0003, 2'b00, 16'h0000, rd);
    chk("ld003", {16'd0, rd}, 32'h5A5A);

    // Reset during an in-flight store
    access("st20_zero", 1'b0, 1'b1, 16'h0020, 2'b11, 16'h0000, rd);
    data_request    = 1'b1;
    write_enable    = 1'b1;
    mem_address     = 16'h0020;
    mem_byte_enable = 2'b11;
    write_data      = 16'hBEEF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      seen = seen | data_response;
    end
    chk("rst_abort_no_resp", {31'd0, seen}, 32'd0);
    chk("rst_abort_rdata", {16'd0, mem_rdata}, 32'd0);
    data_request = 1'b0;
    write_enable = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access("ld20", 1'b0, 1'b0, 16'h0020, 2'b00, 16'h0000, rd);
    chk("ld20_dropped", {16'd0, rd}, 32'h0000);

    // Round-robin ties (pointer back at DATA after reset)
    instruction_address = 16'h0040;
    mem_address = 16'h0010;
    tie("rr1", 1'b0, da, ia, dv, iv);
    chk("rr1_d_at", da, 3);
    chk("rr1_i_at", ia, 7);
    chk("rr1_dval", {16'd0, dv}, 32'h3355);
    chk("rr1_ival", {16'd0, iv}, 32'h1234);
    @(posedge clk); #1;
    tie("rr2", 1'b0, da, ia, dv, iv);
    chk("rr2_i_at", ia, 3);
    chk("rr2_d_at", da, 7);
    chk("rr2_ival", {16'd0, iv}, 32'h1234);
    chk("rr2_dval", {16'd0, dv}, 32'h3355);

    // Fixed priority: data wins every tie
    tie("fx1", 1'b1, da, ia, dv, iv);
    chk("fx1_d_at", da, 3);
    chk("fx1_i_at", ia, 7);
    @(posedge clk); #1;
    tie("fx2", 1'b1, da, ia, dv, iv);
    chk("fx2_d_at", da, 3);
    chk("fx2_i_at", ia, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
